// File: rtl/fsk_bit_decider.sv
// FSK bit decider: gates the tone analyzer for one bit window, latches its tick
// accumulators, decides 0/1/erasure by tone dominance and queues the result in a small FIFO.
module fsk_bit_decider #(
  parameter int unsigned BIT_PERIOD_TICKS      = 5000,
  parameter int unsigned MIN_OCCUPANCY_PERCENT = 50,
  parameter int unsigned FIFO_DEPTH            = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] f0_value,
  input  logic [31:0] f1_value,
  input  logic [31:0] unknown,
  output logic        analyzer_enable,
  output logic        analyzer_clear,
  output logic        bit_data,
  output logic        bit_erasure,
  output logic        bit_valid,
  input  logic        bit_ready,
  output logic        overflow,
  output logic [15:0] bit_count
);

  localparam int unsigned CNT_W   = $clog2(BIT_PERIOD_TICKS);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W   = PTR_W + 1;
  localparam int unsigned SUM_W   = 34;
  localparam int unsigned PROD_W  = 48;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(BIT_PERIOD_TICKS - 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ACQUIRE,
    SETTLE,
    LATCH,
    DECIDE,
    FLUSH
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0] win_cnt;
  logic [31:0]      f0_q;
  logic [31:0]      f1_q;
  logic [31:0]      unk_q;

  logic [SUM_W-1:0]  total;
  logic [31:0]       dom;
  logic [PROD_W-1:0] dom_scaled;
  logic [PROD_W-1:0] total_scaled;
  logic              dec_erasure;
  logic              dec_data;

  logic [1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_next;
  logic             push;
  logic             pop;
  logic             full;
  logic             push_accept;
  logic [1:0]       head_next;

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; dropping enable mid-acquisition abandons the window
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = ACQUIRE;
      ACQUIRE: begin
        if (!enable)                  state_next = FLUSH;
        else if (win_cnt == LAST_TICK) state_next = SETTLE;
      end
      SETTLE:  state_next = LATCH;
      LATCH:   state_next = DECIDE;
      DECIDE:  state_next = FLUSH;
      FLUSH:   state_next = enable ? ACQUIRE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Window counter runs only while staying in ACQUIRE
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      win_cnt <= '0;
    end else if (state == ACQUIRE && state_next == ACQUIRE) begin
      win_cnt <= win_cnt + CNT_W'(1);
    end else begin
      win_cnt <= '0;
    end
  end

  // Analyzer controls are decoded from the upcoming state so they align with it
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      analyzer_enable <= 1'b0;
      analyzer_clear  <= 1'b0;
    end else begin
      analyzer_enable <= (state_next == ACQUIRE);
      analyzer_clear  <= !(state_next == IDLE || state_next == FLUSH);
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      f0_q  <= '0;
      f1_q  <= '0;
      unk_q <= '0;
    end else if (state == LATCH) begin
      f0_q  <= f0_value;
      f1_q  <= f1_value;
      unk_q <= unknown;
    end
  end

  // Dominance test in exact wide arithmetic: dom*100 vs total*percent
  always_comb begin
    total        = SUM_W'(f0_q) + SUM_W'(f1_q) + SUM_W'(unk_q);
    dom          = (f1_q > f0_q) ? f1_q : f0_q;
    dom_scaled   = PROD_W'(dom) * PROD_W'(100);
    total_scaled = PROD_W'(total) * PROD_W'(MIN_OCCUPANCY_PERCENT);
    dec_erasure  = (total == '0) || (f0_q == f1_q) || (dom_scaled < total_scaled);
    dec_data     = !dec_erasure && (f1_q > f0_q);
  end

  // FIFO control; a pop frees a slot in the same cycle a full FIFO is pushed
  always_comb begin
    push        = (state == DECIDE);
    pop         = bit_valid && bit_ready;
    full        = (occ == OCC_FULL);
    push_accept = push && (!full || pop);
    rd_ptr_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    occ_next    = occ;
    if (push_accept && !pop)      occ_next = occ + OCC_W'(1);
    else if (!push_accept && pop) occ_next = occ - OCC_W'(1);
    head_next = mem[rd_ptr_next];
    if (push_accept && (wr_ptr == rd_ptr_next)) head_next = {dec_erasure, dec_data};
  end

  always_ff @(posedge clock) begin
    if (push_accept) mem[wr_ptr] <= {dec_erasure, dec_data};
  end

  // Head-of-queue outputs are registered from the post-update FIFO contents
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ         <= '0;
      bit_valid   <= 1'b0;
      bit_data    <= 1'b0;
      bit_erasure <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr_next;
      occ       <= occ_next;
      bit_valid <= (occ_next != '0);
      if (push_accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (occ_next != '0) begin
        bit_erasure <= head_next[1];
        bit_data    <= head_next[0];
      end else begin
        bit_erasure <= 1'b0;
        bit_data    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      overflow  <= 1'b0;
      bit_count <= '0;
    end else begin
      if (push && full && !pop) overflow <= 1'b1;
      if (push) bit_count <= bit_count + 16'd1;
    end
  end

endmodule

// File: doc/fsk_bit_decider.md
FSK_BIT_DECIDER -- requirements
Module: fsk_bit_decider

Interface
REQ-001 SHALL have parameter BIT_PERIOD_TICKS, default 5000, meaning clock cycles per bit window (≥ 8).
REQ-002 SHALL have parameter MIN_OCCUPANCY_PERCENT, default 50, meaning minimum percentage of window ticks the dominant tone must hold (1..100).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning output bit FIFO entries (power of two).
REQ-004 SHALL have port clock  in  1  single system clock; all logic on posedge.
REQ-005 SHALL have port clear  in  1  asynchronous active-low reset.
REQ-006 SHALL have port enable  in  1  run request; high = decode successive windows.
REQ-007 SHALL have ports f0_value, f1_value, unknown  in  32 each  tick accumulators from the upstream frequency analyzer.
REQ-008 SHALL have port analyzer_enable  out  1  enable driven to the analyzer.
REQ-009 SHALL have port analyzer_clear  out  1  active-low clear driven to the analyzer.
REQ-010 SHALL have ports bit_data  out  1 and bit_erasure  out  1  FIFO head: decided bit and "undecidable" flag.
REQ-011 SHALL have ports bit_valid  out  1 and bit_ready  in  1  valid/ready handshake for the FIFO head.
REQ-012 SHALL have port overflow  out  1  sticky: a decision was dropped because the FIFO was full.
REQ-013 SHALL have port bit_count  out  16  number of decisions produced, wraps 0xFFFF->0.

Function
REQ-014 SHALL implement states IDLE, ACQUIRE, SETTLE, LATCH, DECIDE, FLUSH; analyzer_enable and analyzer_clear are registered outputs decoded from state.
REQ-015 SHALL drive analyzer_clear=0 in IDLE and FLUSH, 1 otherwise; analyzer_enable=1 only in ACQUIRE.
REQ-016 SHALL move IDLE->ACQUIRE on the first cycle enable=1; ACQUIRE lasts exactly BIT_PERIOD_TICKS cycles via a window counter (0..BIT_PERIOD_TICKS-1).
REQ-017 SHALL then go SETTLE (1 cycle, lets the analyzer fold its partial count into unknown), LATCH (1 cycle, capture all three inputs), DECIDE (1 cycle), FLUSH (1 cycle); full window period = BIT_PERIOD_TICKS+4 cycles.
REQ-018 SHALL go FLUSH->ACQUIRE if enable=1, else FLUSH->IDLE.
REQ-019 SHALL, if enable falls during ACQUIRE, go directly to FLUSH, discard the partial window, push nothing, and not increment bit_count.
REQ-020 SHALL ignore enable changes during SETTLE, LATCH and DECIDE (window completes).
REQ-021 SHALL compute in DECIDE: total=f0+f1+unknown (34-bit, no overflow); dom=max(f0,f1).
REQ-022 SHALL set erasure=1, bit_data=0 if total==0, or f0==f1, or dom*100 < total*MIN_OCCUPANCY_PERCENT (products ≥41 bits, exact).
REQ-023 SHALL otherwise set erasure=0, bit_data=1 if f1>f0, bit_data=0 if f0>f1.
REQ-024 SHALL push {erasure,bit_data} into the FIFO at the end of DECIDE and increment bit_count by 1 regardless of FIFO state.
REQ-025 SHALL assert bit_valid whenever the FIFO is non-empty; a pop occurs on a cycle with bit_valid=1 and bit_ready=1; bit_data/bit_erasure reflect the head and hold stable while bit_valid=1 and bit_ready=0.
REQ-026 SHALL, on push while full with no pop that cycle, drop the new entry and set overflow=1 until reset.
REQ-027 SHALL, on simultaneous push and pop while full, accept the push (no overflow); simultaneous push and pop while empty is impossible (bit_valid=0, no pop).
REQ-028 SHALL, with bit_ready held high, present a decision with bit_valid=1 one cycle after DECIDE (FLUSH cycle).

Reset
REQ-029 SHALL, while clear=0, asynchronously force: state IDLE, window counter 0, FIFO empty, bit_valid=0, bit_data=0, bit_erasure=0, overflow=0, bit_count=0, analyzer_enable=0, analyzer_clear=0.
REQ-030 SHALL, on clear asserted mid-window, abandon the window with no push; after release resume from IDLE.

Verification (BIT_PERIOD_TICKS=100, MIN_OCCUPANCY_PERCENT=50, FIFO_DEPTH=4)
REQ-031 SHALL cover: enable=1, ready=1, inputs at LATCH f0=80,f1=10,unknown=10 -> bit_valid=1 at cycle 104 after leaving IDLE, bit_data=0, bit_erasure=0, bit_count=1.
REQ-032 SHALL cover: f0=20,f1=60,unknown=20 -> bit_data=1, erasure=0; f0=30,f1=30,unknown=40 -> erasure=1, bit_data=0.
REQ-033 SHALL cover: f0=40,f1=5,unknown=55 (4000<5000) -> erasure=1; f0=0,f1=0,unknown=0 -> erasure=1.
REQ-034 SHALL cover: bit_ready=0 for 5 windows -> 4 entries held in order, overflow=1, bit_count=5; then ready=1 drains exactly 4 entries.
REQ-035 SHALL cover: enable dropped at ACQUIRE cycle 50 -> one FLUSH cycle (analyzer_clear=0), then IDLE, bit_count unchanged, no bit_valid.
REQ-036 SHALL cover: clear pulsed low mid-ACQUIRE with 2 entries queued -> all outputs at reset values immediately, no stale entry after release.
